// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MIPS R-format funct codes accepted by the unit
//   - FSM state encoding
//   - small decode helpers for the funct field
package mdu_pkg;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // True for the four commands that run the iterative datapath.
  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic is_div(input logic [5:0] f);
    return (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: command/result bundle between the execute stage and the
// multiply/divide unit.
//   start, funct, Read_A, Read_B : command from the pipeline (master drives)
//   hi, lo                       : HI/LO registers (unit drives)
//   busy, done, div_zero         : status (unit drives)
interface mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] Read_A;
  logic [WIDTH-1:0] Read_B;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, funct, Read_A, Read_B,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, funct, Read_A, Read_B,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the unsigned magnitude datapath.
//   div_i   : 0 = shift-add multiply step, 1 = restoring shift-subtract step
//   acc_i   : 2*WIDTH working accumulator
//             multiply: {partial product high, multiplier / product low}
//             divide  : {partial remainder, dividend / quotient bits}
//   opnd_i  : multiplicand (multiply) or divisor (divide) magnitude
//   acc_o   : accumulator after this iteration
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit (LSB) is set, then shift right. The carry out of the add
  // becomes the new MSB, so no extra accumulator bit is needed.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
  assign mul_next = {mul_sum, acc_i[WIDTH-1:1]};

  // Divide: shift the next dividend bit into the partial remainder and try a
  // subtraction. The remainder is always below the divisor, so the shifted
  // value fits in WIDTH+1 bits and a kept result fits back in WIDTH.
  logic [WIDTH:0]       rem_shift;
  logic                 q_bit;
  logic [WIDTH-1:0]     rem_next;
  logic [2*WIDTH-1:0]   div_next;

  assign rem_shift = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
  assign q_bit     = (rem_shift >= {1'b0, opnd_i});
  assign rem_next  = q_bit ? WIDTH'(rem_shift - {1'b0, opnd_i}) : rem_shift[WIDTH-1:0];
  assign div_next  = {rem_next, acc_i[WIDTH-2:0], q_bit};

  assign acc_o = div_i ? div_next : mul_next;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with HI/LO registers.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   bus.start / bus.funct / bus.Read_A / bus.Read_B : command inputs
//   bus.hi / bus.lo      : HI/LO registers
//   bus.busy             : iterative op in progress
//   bus.done             : one-cycle pulse when HI/LO were written by an op
//   bus.div_zero         : one-cycle pulse with done for a divide by zero
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles (IDLE -> CALC x WIDTH -> FIX).
// MTHI/MTLO write in one cycle when idle. All outputs come from flops.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_flag_q, dz_flag_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_out_q, dz_out_d;

  // Operand decode. Negating MIN yields MIN, which read as unsigned is
  // exactly 2^(WIDTH-1), the required magnitude.
  logic               op_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign op_signed = is_signed_op(bus.funct);
  assign a_neg     = op_signed & bus.Read_A[WIDTH-1];
  assign b_neg     = op_signed & bus.Read_B[WIDTH-1];
  assign a_mag     = a_neg ? -bus.Read_A : bus.Read_A;
  assign b_mag     = b_neg ? -bus.Read_B : bus.Read_B;

  logic [2*WIDTH-1:0] acc_step;

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .div_i  (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  // Sign fix-up of the finished magnitudes.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_mag, rem_mag;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign prod_fix = res_neg_q ? -acc_q : acc_q;
  assign rem_mag  = acc_q[2*WIDTH-1:WIDTH];
  assign quot_mag = acc_q[WIDTH-1:0];
  assign quot_fix = res_neg_q ? -quot_mag : quot_mag;
  assign rem_fix  = rem_neg_q ? -rem_mag : rem_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_flag_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      dz_flag_q <= dz_flag_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_out_q  <= dz_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    dz_flag_d = dz_flag_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_out_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_muldiv(bus.funct)) begin
            div_d     = is_div(bus.funct);
            res_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            dz_flag_d = is_div(bus.funct) && (bus.Read_B == '0);
            // Divide shifts the dividend out of the low half; multiply
            // consumes the multiplier from the low half.
            if (is_div(bus.funct)) begin
              acc_d  = {{WIDTH{1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
            cnt_d   = '0;
            state_d = CALC;
          end else if (bus.funct == FN_MTHI) begin
            hi_d = bus.Read_A;
          end else if (bus.funct == FN_MTLO) begin
            lo_d = bus.Read_A;
          end
        end
      end

      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (div_q) begin
          // With a zero divisor every trial subtract succeeds, so the
          // remainder ends up holding the dividend magnitude and the sign
          // fix-up restores the original Read_A for hi on its own.
          lo_d = dz_flag_q ? '1 : quot_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d   = 1'b1;
        dz_out_d = dz_flag_q;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_out_q;

endmodule
